// File: rtl/regfile_writeback.sv
// Write-back queue: two producers (load path over ALU) feed an in-order FIFO
// that drives the register file's single write port and a per-register pending mask.
module regfile_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       wb_stall,
    output logic                       reg_write,
    output logic [ADDR_W-1:0]          write_register,
    output logic [DATA_W-1:0]          write_data,
    output logic [2**ADDR_W-1:0]       pending,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full, empty, enq, deq;
    logic [ADDR_W-1:0] enq_reg;
    logic [DATA_W-1:0] enq_data;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign enq       = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign deq       = !empty && !wb_stall;
    assign enq_reg   = mem_valid ? mem_reg  : alu_reg;
    assign enq_data  = mem_valid ? mem_data : alu_data;

    // Write port is decoded from the queue head only, so it holds through the falling edge.
    assign reg_write      = deq;
    assign write_register = deq ? reg_q[rd_ptr_q]  : '0;
    assign write_data     = deq ? data_q[rd_ptr_q] : '0;
    assign fifo_count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk occupied slots from the head; pointers wrap since DEPTH is a power of two.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pending = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) pending[reg_q[idx]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            reg_q[wr_ptr_q]  <= enq_reg;
            data_q[wr_ptr_q] <= enq_data;
        end
    end

    logic unused_nreg;
    assign unused_nreg = (NREG == 0);
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed vector bench for regfile_writeback with a falling-edge register-file model.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid, wb_stall;
    logic [4:0]  mem_reg, alu_reg;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [2:0]  fifo_count;
    logic [31:0] rf [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .wb_stall(wb_stall), .reg_write(reg_write), .write_register(write_register),
        .write_data(write_data), .pending(pending), .fifo_count(fifo_count)
    );

    always @(negedge clk) if (reg_write) rf[write_register] <= write_data;

    typedef struct {
        logic        mv; logic [4:0] mr; logic [31:0] md;
        logic        av; logic [4:0] ar; logic [31:0] ad;
        logic        st;
        logic        e_rw; logic [4:0] e_wr; logic [31:0] e_wd;
        logic        e_mr, e_ar; logic [31:0] e_pend; logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic mv, logic [4:0] mr, logic [31:0] md,
                                logic av, logic [4:0] ar, logic [31:0] ad, logic st,
                                logic e_rw, logic [4:0] e_wr, logic [31:0] e_wd,
                                logic e_mr, logic e_ar, logic [31:0] e_pend, logic [2:0] e_cnt);
        vec_t v;
        v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad; v.st = st;
        v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
        v.e_mr = e_mr; v.e_ar = e_ar; v.e_pend = e_pend; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_reg = '0; mem_data = '0;
        alu_valid = 0; alu_reg = '0; alu_data = '0;
        wb_stall  = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        mem_valid = 1;
        #2;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_write_reg", write_register, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_alu_ready_memv", alu_ready, 0);
        mem_valid = 0;
        #1;
        chk("rst_alu_ready", alu_ready, 1);
        #7 rst_n = 1;
        tick();

        //           mv mr  md            av ar  ad    st  rw wr  wd            mr ar pend          cnt
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           1, 3, 'hAA,  0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 3, 'hAA,        1, 1, 32'h8,      1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(1, 5, 'h55,        1, 6, 'h66,  0,  0, 0, 0,           1, 0, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           1, 6, 'h66,  0,  1, 5, 'h55,        1, 1, 32'h20,     1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 6, 'h66,        1, 1, 32'h40,     1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           1, 1, 'h11,  1,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           1, 2, 'h22,  1,  0, 0, 0,           1, 1, 32'h02,     1));
        vecs.push_back(mk(0, 0, 0,           1, 3, 'h33,  1,  0, 0, 0,           1, 1, 32'h06,     2));
        vecs.push_back(mk(0, 0, 0,           1, 4, 'h44,  1,  0, 0, 0,           1, 1, 32'h0E,     3));
        vecs.push_back(mk(0, 0, 0,           1, 9, 'h99,  1,  0, 0, 0,           0, 0, 32'h1E,     4));
        vecs.push_back(mk(0, 0, 0,           1, 9, 'h99,  0,  1, 1, 'h11,        0, 0, 32'h1E,     4));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 2, 'h22,        1, 1, 32'h1C,     3));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 3, 'h33,        1, 1, 32'h18,     2));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 4, 'h44,        1, 1, 32'h10,     1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           1, 7, 'h1,   0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           1, 7, 'h2,   1,  0, 0, 0,           1, 1, 32'h80,     1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 7, 'h1,         1, 1, 32'h80,     2));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 7, 'h2,         1, 1, 32'h80,     1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  0, 0, 0,           1, 1, 32'h0,      0));
        vecs.push_back(mk(1, 0, 'hDEADBEEF,  0, 0, 0,     0,  0, 0, 0,           1, 0, 32'h0,      0));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  1, 0, 'hDEADBEEF,  1, 1, 32'h1,      1));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,     0,  0, 0, 0,           1, 1, 32'h0,      0));

        foreach (vecs[i]) begin
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            wb_stall  = vecs[i].st;
            #1;
            chk($sformatf("vec%0d_reg_write", i), reg_write, vecs[i].e_rw);
            chk($sformatf("vec%0d_write_reg", i), write_register, vecs[i].e_wr);
            chk($sformatf("vec%0d_write_data", i), write_data, vecs[i].e_wd);
            chk($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("vec%0d_pending", i), pending, vecs[i].e_pend);
            chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].e_cnt);
            tick();
        end
        idle_inputs();
        chk("rf_r7_last", rf[7], 32'h2);
        chk("rf_r0_written", rf[0], 32'hDEADBEEF);
        chk("rf_r9_never", rf[9] === 32'h99, 0);

        // Reset mid-operation with three queued entries.
        wb_stall = 1; alu_valid = 1;
        for (int k = 0; k < 3; k++) begin
            alu_reg = 5'(10 + k); alu_data = 32'(32'hA0 + k);
            tick();
        end
        idle_inputs();
        #1;
        chk("mid_pre_count", fifo_count, 3);
        chk("mid_pre_write", reg_write, 1);
        chk("mid_pre_reg", write_register, 10);
        rst_n = 0;
        #1;
        chk("mid_rst_write", reg_write, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_count", fifo_count, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("post_rst_idle", reg_write, 0);
        alu_valid = 1; alu_reg = 13; alu_data = 32'h1313;
        tick();
        idle_inputs();
        #1;
        chk("post_rst_write", reg_write, 1);
        chk("post_rst_reg", write_register, 13);
        chk("post_rst_data", write_data, 32'h1313);
        chk("post_rst_count", fifo_count, 1);
        tick();

        // Continuous ALU stream with no stall.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                alu_valid = 1; alu_reg = 5'(16 + i); alu_data = 32'(32'h1000 + i);
            end else begin
                idle_inputs();
            end
            #1;
            chk($sformatf("stream%0d_count_le1", i), fifo_count <= 1, 1);
            if (i == 0) begin
                chk("stream0_write", reg_write, 0);
            end else begin
                chk($sformatf("stream%0d_write", i), reg_write, 1);
                chk($sformatf("stream%0d_reg", i), write_register, 16 + i - 1);
                chk($sformatf("stream%0d_data", i), write_data, 32'h1000 + i - 1);
            end
            tick();
        end
        #1;
        chk("stream_end_write", reg_write, 0);
        chk("stream_rf_r23", rf[23], 32'h1007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back queue and arbiter that drives the register file's single write port. It accepts write-back requests from two producers (ALU result path and memory load path) over valid/ready handshakes and buffers them in a small in-order FIFO. It presents one write per cycle on `reg_write`/`write_register`/`write_data`, stable across the falling edge on which the register file commits. It also reports a per-register pending mask for hazard detection.

## Interface
- `DATA_W`, 32, width of write data
- `ADDR_W`, 5, register index width; register count is 2**ADDR_W
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_valid`  in  1  load-path write request
- `mem_ready`  out  1  load-path request accepted this cycle when high with `mem_valid`
- `mem_reg`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load data
- `alu_valid`  in  1  ALU-path write request
- `alu_ready`  out  1  ALU-path handshake ready
- `alu_reg`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `wb_stall`  in  1  when high, hold the queue: no write issued, no dequeue
- `reg_write`  out  1  write enable to the register file
- `write_register`  out  ADDR_W  write destination
- `write_data`  out  DATA_W  write value
- `pending`  out  2**ADDR_W  bit r high if any queued entry targets register r
- `fifo_count`  out  $clog2(DEPTH+1)  entries currently queued

## Operation
- FIFO with a write pointer, a read pointer and a count. Pointers wrap modulo DEPTH.
- Arbitration is fixed priority: memory over ALU.
  - `mem_ready = !full`
  - `alu_ready = !full && !mem_valid`
  - At most one enqueue per cycle.
- Enqueue on a rising edge when (`mem_valid && mem_ready`) or (`alu_valid && alu_ready`). The entry stores {reg, data} of the winner.
- Drain:
  - When not empty and `wb_stall` is low: `reg_write=1`, `write_register`/`write_data` equal the head entry. The head is dequeued on the next rising edge.
  - When empty or `wb_stall` is high: `reg_write=0`, `write_register=0`, `write_data=0`.
- Outputs are decoded from registered state only; no combinational path from `*_valid` or `*_data` to `reg_write`/`write_*`.
- Simultaneous enqueue and dequeue in one cycle leaves the count unchanged and is legal at any non-full occupancy.
- When full, the ready signals are low even if a dequeue occurs in the same cycle. Full-state throughput is therefore one slot per two cycles; this is intended.
- Writes to every register index, including 0, are queued and issued unchanged.
- Multiple entries to the same register are issued in arrival order; there is no coalescing.
- `pending` is the OR over valid entries of a one-hot decode of each entry's register. It excludes the request being accepted this cycle.

## Timing
- Reset (asynchronous assert, synchronous release to next rising edge):
  - count=0, pointers=0
  - `reg_write=0`, `write_register=0`, `write_data=0`, `pending=0`, `fifo_count=0`
  - `mem_ready=1`, `alu_ready=!mem_valid`
- Reset asserted mid-operation discards all queued entries immediately. No write is issued while `rst_n` is low.
- Latency: a request accepted at rising edge N into an empty FIFO drives `reg_write=1` from edge N to edge N+1. The register file commits it on the intervening falling edge.
- Throughput: one write per cycle while not stalled and not full.
- `wb_stall` is sampled every cycle. Asserting it suppresses `reg_write` in that same cycle and blocks the dequeue at the next edge.
- `fifo_count` and `pending` update on the same rising edge as the enqueue/dequeue that changes them.

## Test plan
- Reset, then `alu_valid=1`, `alu_reg=3`, `alu_data=0x0000_00AA` for one cycle -> next cycle `reg_write=1`, `write_register=3`, `write_data=0xAA`, `pending[3]=1`, `fifo_count=1`; following cycle `reg_write=0`, `pending=0`.
- `mem_valid` and `alu_valid` both high (mem r5=0x55, alu r6=0x66) -> `alu_ready=0`; r5 issued first; r6 accepted once `mem_valid` drops; issue order r5 then r6.
- `wb_stall=1`, push 4 ALU writes r1..r4 -> `fifo_count=4`, both readies low, `reg_write=0`, `pending=0x1E`; release stall -> writes r1,r2,r3,r4 on 4 consecutive cycles.
- Two queued writes to r7 (0x1, then 0x2) -> issued in order; `pending[7]` stays high until the second dequeues; the register file ends at 0x2.
- With 3 entries queued, pull `rst_n` low between edges -> `reg_write`, `pending`, `fifo_count` go to 0 immediately; after release the first new request issues with 1-cycle latency.
- Continuous ALU stream of 8 writes, no stall -> `fifo_count` never exceeds 1; 8 `reg_write` pulses on consecutive cycles with matching register/data.
